scntr_mod_p: RTL and testbench
==============================

# scntr_mod_p

Parametrised synchronous N-bit up/down counter with programmable runtime terminal value, parallel load, three terminal behaviours (wrap, saturate, one-shot) and a cascade carry chain. Successor to the fixed-width preset/load counter in the datapath library. Used for loop counters, timers and address generators in the datapath group. Slices chain through COUT→CIN for widths beyond N.

## Interface
- N, 8, counter width (1..32)
- RST_VAL, 0, value loaded into Q on reset; must be ≤ 2^N−1
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous active-high reset
- EN  in  1  count enable
- CIN  in  1  cascade enable; tie high on the least-significant slice
- UP  in  1  direction: 1 = up, 0 = down
- PL  in  1  parallel load strobe
- D  in  N  parallel load data
- LIMIT  in  N  terminal value for up-count; down-count terminal is 0
- MODE  in  2  00 wrap, 01 saturate, 10 one-shot, 11 behaves as 00
- Q  out  N  count value, registered
- TC  out  1  terminal condition, combinational
- COUT  out  1  cascade carry, combinational
- DONE  out  1  one-shot completion flag, registered, sticky

## Operation
- Priority per edge: RST > PL > count step > hold.
- RST: Q←RST_VAL, DONE←0.
- PL (RST low): Q←D, DONE←0. EN, CIN and MODE are ignored.
- Step condition: STEP = EN & CIN & ~DONE & ~PL & ~RST.
- TC = UP ? (Q ≥ LIMIT) : (Q == 0). Unsigned compare, independent of EN.
- On STEP with TC=0: Q←Q+1 (UP) or Q−1 (down), mod 2^N.
- On STEP with TC=1:
  - MODE 00/11 (wrap): Q←0 when counting up; Q←LIMIT when counting down.
  - MODE 01 (saturate): Q holds.
  - MODE 10 (one-shot): Q holds and DONE←1.
- DONE=1 freezes Q in every mode until PL or RST. MODE changes do not clear DONE.
- Q > LIMIT while counting up (loaded or LIMIT lowered) counts as terminal and follows the rules above.
- LIMIT=0 while counting up: TC is permanently 1. Wrap holds Q at 0; one-shot sets DONE on the first STEP.
- UP, LIMIT and MODE may change on any cycle. The next edge uses the values present at that edge.
- COUT = TC & EN & CIN & ~DONE.

## Timing
- Q and DONE change one cycle after the qualifying edge inputs; there is no pipeline.
- TC and COUT are combinational from Q, UP, LIMIT, EN, CIN and DONE. They are valid the same cycle and carry no input-to-output register.
- Cascade: connect slice k COUT to slice k+1 CIN, with shared EN, UP and MODE. The upper slice steps on the same edge its lower slice wraps.
  - In a cascade, set LIMIT = all-ones on every slice except the top.
- Reset values: Q=RST_VAL, DONE=0. TC and COUT are derived from these.
- Setup and hold on D, PL, EN, UP, LIMIT and MODE are relative to the CLK rising edge. Timing checks carry zero-valued specparams, as in the rest of the library.

## Structure
- Shared package scntr_pkg holds:
  - MODE encodings SCNTR_WRAP=2'b00, SCNTR_SAT=2'b01, SCNTR_ONESHOT=2'b10.
  - A width-check constant used by all counter variants.
- One combinational sub-module, scntr_step. Inputs: Q, UP, LIMIT, MODE. Outputs: next value, TC, and set_done.
- The top level holds the Q and DONE registers, the priority mux, and the COUT gating.

## Test plan
- N=8, MODE=00, LIMIT=5, UP=1, EN=CIN=1 from Q=0 → Q cycles 0,1,2,3,4,5,0. TC=1 only while Q=5. COUT pulses once per wrap.
- UP=0, MODE=00, LIMIT=9, PL with D=2, then count → Q goes 2,1,0,9,8. TC=1 only at Q=0.
- MODE=01, LIMIT=3, UP=1, 6 enables → Q sticks at 3 and TC stays 1. Flip UP=0 → Q goes 2 on the next edge.
- MODE=10, LIMIT=4, count from 0 → Q reaches 4. DONE rises one edge later and Q freezes. Flip UP → no motion. PL with D=1 → DONE=0 and counting resumes.
- RST and PL asserted together with D=0xAA, RST_VAL=0x10 → Q=0x10. RST asserted mid-count in one-shot after DONE=1 → Q=RST_VAL, DONE=0.
- Two 4-bit slices cascaded, LIMIT=0xF on both, MODE=00, up → combined value counts 0x0F→0x10. The top slice steps only on the lower COUT. Deassert CIN on the low slice → both hold.

Source files
------------

// File: rtl/scntr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scntr_pkg : shared mode encodings and width limit for the counter family
// Rev 1.0
// ---------------------------------------------------------------------------
package scntr_pkg;

  localparam int unsigned SCNTR_MAX_W = 32;

  typedef enum logic [1:0] {
    SCNTR_WRAP     = 2'b00,
    SCNTR_SAT      = 2'b01,
    SCNTR_ONESHOT  = 2'b10,
    SCNTR_WRAP_ALT = 2'b11
  } scntr_mode_e;

endpackage
`default_nettype wire

// File: rtl/scntr_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scntr_step : combinational next-value, terminal and one-shot decode
// Rev 1.0
// ---------------------------------------------------------------------------
module scntr_step
  import scntr_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] i_q,
  input  logic         i_up,
  input  logic [N-1:0] i_limit,
  input  logic [1:0]   i_mode,
  output logic [N-1:0] o_next,
  output logic         o_tc,
  output logic         o_set_done
);

  localparam logic [N-1:0] c_ONE = N'(1);

  always_comb begin
    o_tc       = i_up ? (i_q >= i_limit) : (i_q == '0);
    o_next     = i_q;
    o_set_done = 1'b0;
    if (!o_tc) begin
      o_next = i_up ? (i_q + c_ONE) : (i_q - c_ONE);
    end else begin
      case (i_mode)
        SCNTR_SAT:     o_next = i_q;
        SCNTR_ONESHOT: o_set_done = 1'b1;
        // Down-count wraps to LIMIT so the cascade's low slice reloads all-ones.
        default:       o_next = i_up ? '0 : i_limit;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/scntr_mod_p.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scntr_mod_p : N-bit up/down counter, runtime limit, load, cascade carry
// Rev 1.0
// ---------------------------------------------------------------------------
module scntr_mod_p
  import scntr_pkg::*;
#(
  parameter int unsigned              N       = 8,
  parameter logic [SCNTR_MAX_W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_cin,
  input  logic         i_up,
  input  logic         i_pl,
  input  logic [N-1:0] i_d,
  input  logic [N-1:0] i_limit,
  input  logic [1:0]   i_mode,
  output logic [N-1:0] o_q,
  output logic         o_tc,
  output logic         o_cout,
  output logic         o_done
);

  localparam logic [N-1:0] c_RST_Q = RST_VAL[N-1:0];

  logic [N-1:0] r_q;
  logic         r_done;
  logic [N-1:0] w_next;
  logic         w_tc;
  logic         w_set_done;
  logic         w_step;

  scntr_step #(.N(N)) u_step (
    .i_q        (r_q),
    .i_up       (i_up),
    .i_limit    (i_limit),
    .i_mode     (i_mode),
    .o_next     (w_next),
    .o_tc       (w_tc),
    .o_set_done (w_set_done)
  );

  // PL and RST are excluded by the priority chain below.
  assign w_step = i_en & i_cin & ~r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= c_RST_Q;
      r_done <= 1'b0;
    end else if (i_pl) begin
      r_q    <= i_d;
      r_done <= 1'b0;
    end else if (w_step) begin
      r_q    <= w_next;
      r_done <= w_set_done;
    end
  end

  assign o_q    = r_q;
  assign o_done = r_done;
  assign o_tc   = w_tc;
  assign o_cout = w_tc & w_step;

endmodule
`default_nettype wire

// File: tb/tb_scntr_mod_p.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_scntr_mod_p : directed + random check against an arithmetic reference
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_scntr_mod_p;

  localparam int RSTV = 16;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, pl = 1'b0, en = 1'b0, cin = 1'b1, up = 1'b1;
  logic [7:0] d = '0, lim = '0;
  logic [1:0] mode = '0;
  logic [7:0] q;
  logic       tc, cout, done;

  scntr_mod_p #(.N(8), .RST_VAL(32'h10)) dut (
    .clk(clk), .rst(rst), .i_en(en), .i_cin(cin), .i_up(up), .i_pl(pl),
    .i_d(d), .i_limit(lim), .i_mode(mode),
    .o_q(q), .o_tc(tc), .o_cout(cout), .o_done(done)
  );

  // Two 4-bit slices chained through carry
  logic       c_rst = 1'b1, c_pl = 1'b0, c_en = 1'b0, c_cin = 1'b1, c_up = 1'b1;
  logic [3:0] d_lo = '0, d_hi = '0;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, tc_hi, cout_lo, cout_hi, done_lo, done_hi;

  scntr_mod_p #(.N(4), .RST_VAL(32'h0)) u_lo (
    .clk(clk), .rst(c_rst), .i_en(c_en), .i_cin(c_cin), .i_up(c_up), .i_pl(c_pl),
    .i_d(d_lo), .i_limit(4'hF), .i_mode(2'b00),
    .o_q(q_lo), .o_tc(tc_lo), .o_cout(cout_lo), .o_done(done_lo)
  );
  scntr_mod_p #(.N(4), .RST_VAL(32'h0)) u_hi (
    .clk(clk), .rst(c_rst), .i_en(c_en), .i_cin(cout_lo), .i_up(c_up), .i_pl(c_pl),
    .i_d(d_hi), .i_limit(4'hF), .i_mode(2'b00),
    .o_q(q_hi), .o_tc(tc_hi), .o_cout(cout_hi), .o_done(done_hi)
  );

  int n_chk = 0, n_err = 0;
  int mq = RSTV, md = 0, cm = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_tc();
    return up ? int'(mq >= int'(lim)) : int'(mq == 0);
  endfunction

  // Check combinational outputs, take one edge, update the reference, check state.
  task automatic cycle();
    int t;
    #1;
    t = m_tc();
    chk("tc", 32'(tc), 32'(t));
    chk("cout", 32'(cout), 32'(t != 0 && en && cin && md == 0));
    @(posedge clk);
    if (rst) begin
      mq = RSTV; md = 0;
    end else if (pl) begin
      mq = int'(d); md = 0;
    end else if (en && cin && md == 0) begin
      if (t == 0)             mq = up ? (mq + 1) % 256 : (mq + 255) % 256;
      else if (mode == 2'b10) md = 1;
      else if (mode != 2'b01) mq = up ? 0 : int'(lim);
    end
    #1;
    chk("q", 32'(q), 32'(mq));
    chk("done", 32'(done), 32'(md));
  endtask

  task automatic drv(input logic r, input logic p, input logic e, input logic u,
                     input logic [7:0] dd, input logic [7:0] ll, input logic [1:0] m);
    rst = r; pl = p; en = e; up = u; d = dd; lim = ll; mode = m; cin = 1'b1;
    cycle();
  endtask

  task automatic ccycle();
    int t;
    #1;
    t = c_up ? int'((cm % 16) == 15) : int'((cm % 16) == 0);
    chk("casc_cout", 32'(cout_lo), 32'(t != 0 && c_en && c_cin));
    @(posedge clk);
    if (c_rst)               cm = 0;
    else if (c_pl)           cm = int'({d_hi, d_lo});
    else if (c_en && c_cin)  cm = c_up ? (cm + 1) % 256 : (cm + 255) % 256;
    #1;
    chk("casc_q", 32'({q_hi, q_lo}), 32'(cm));
  endtask

  int exp_w[7] = '{1, 2, 3, 4, 5, 0, 1};
  int exp_d[4] = '{1, 0, 9, 8};

  initial begin
    drv(1, 0, 0, 1, 8'h00, 8'h00, 2'b00);
    chk("rst_q", 32'(q), 32'h10);
    chk("rst_done", 32'(done), 32'h0);

    // Wrap up to LIMIT=5
    drv(0, 1, 0, 1, 8'h00, 8'd5, 2'b00);
    for (int i = 0; i < 7; i++) begin
      drv(0, 0, 1, 1, 8'h00, 8'd5, 2'b00);
      chk("wrap_seq", 32'(q), 32'(exp_w[i]));
    end

    // Down-count wrap to LIMIT=9
    drv(0, 1, 1, 0, 8'd2, 8'd9, 2'b00);
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 1, 0, 8'h00, 8'd9, 2'b00);
      chk("down_seq", 32'(q), 32'(exp_d[i]));
    end

    // Saturate at 3, then turn around
    drv(0, 1, 0, 1, 8'd0, 8'd3, 2'b01);
    for (int i = 0; i < 6; i++) drv(0, 0, 1, 1, 8'h00, 8'd3, 2'b01);
    chk("sat_hold", 32'(q), 32'd3);
    drv(0, 0, 1, 0, 8'h00, 8'd3, 2'b01);
    chk("sat_down", 32'(q), 32'd2);

    // One-shot to 4, freeze, reload
    drv(0, 1, 0, 1, 8'd0, 8'd4, 2'b10);
    for (int i = 0; i < 5; i++) drv(0, 0, 1, 1, 8'h00, 8'd4, 2'b10);
    chk("os_q", 32'(q), 32'd4);
    chk("os_done", 32'(done), 32'd1);
    drv(0, 0, 1, 0, 8'h00, 8'd4, 2'b00);
    chk("os_frozen", 32'(q), 32'd4);
    drv(0, 1, 1, 1, 8'd1, 8'd4, 2'b10);
    chk("os_pl_done", 32'(done), 32'd0);
    drv(0, 0, 1, 1, 8'h00, 8'd4, 2'b10);
    chk("os_resume", 32'(q), 32'd2);

    // RST beats PL; RST clears DONE
    drv(1, 1, 1, 1, 8'hAA, 8'd4, 2'b10);
    chk("rst_pl", 32'(q), 32'h10);
    drv(0, 1, 0, 1, 8'd0, 8'd0, 2'b10);
    drv(0, 0, 1, 1, 8'h00, 8'd0, 2'b10);
    chk("lim0_done", 32'(done), 32'd1);
    drv(1, 0, 1, 1, 8'h00, 8'd0, 2'b10);
    chk("rst_os_q", 32'(q), 32'h10);
    chk("rst_os_done", 32'(done), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 39) == 0);
      pl   = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 3) != 0);
      cin  = ($urandom_range(0, 7) != 0);
      up   = 1'($urandom);
      d    = 8'($urandom);
      lim  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      mode = 2'($urandom);
      cycle();
    end

    // Cascade
    c_rst = 1'b1; ccycle();
    c_rst = 1'b0; c_pl = 1'b1; d_lo = 4'hF; d_hi = 4'h0; ccycle();
    c_pl = 1'b0; c_en = 1'b1; c_up = 1'b1; ccycle();
    chk("casc_0x10", 32'({q_hi, q_lo}), 32'h10);
    c_cin = 1'b0; ccycle();
    chk("casc_hold", 32'({q_hi, q_lo}), 32'h10);
    for (int i = 0; i < 120; i++) begin
      c_en  = ($urandom_range(0, 5) != 0);
      c_cin = ($urandom_range(0, 5) != 0);
      c_up  = ($urandom_range(0, 3) != 0);
      ccycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
